// File: rtl/signed_subtractor_seq_if.sv
// Start/done handshake and operand/result bus for the digit-serial signed subtractor.
// master drives the request; slave (the subtractor) drives status and result.
interface signed_subtractor_seq_if #(
    parameter int SIZE = 8
) ();
    logic            start;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            bin;
    logic            ready;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] diff;
    logic            bout;
    logic            overflow;

    modport master (
        output start, a, b, bin,
        input  ready, busy, done, diff, bout, overflow
    );

    modport slave (
        input  start, a, b, bin,
        output ready, busy, done, diff, bout, overflow
    );
endinterface

// File: rtl/signed_subtractor_seq.sv
// Digit-serial signed subtractor: diff = a - b - bin over SIZE/DIGIT cycles, start/done handshake.
// Optional SUB_SATURATE_EN clamps diff on signed overflow instead of wrapping.
module signed_subtractor_seq #(
    parameter int SIZE  = 8,
    parameter int DIGIT = 2
) (
    input logic                  clk,
    input logic                  reset,
    signed_subtractor_seq_if.slave bus
);
    localparam int N     = SIZE / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [SIZE-1:0] a_q, b_q, res_q, diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic            carry_q, a_sign_q, b_sign_q;
    logic            ready_q, busy_q, done_q, bout_q, ovf_q;

    logic [DIGIT:0]  digit_sum;
    logic [SIZE-1:0] res_d, diff_d;
    logic            carry_d, ovf_d, last_digit;

    // a - b - bin is evaluated as a + ~b + (1 - bin); the carry register holds ~bin initially.
    always_comb begin
        digit_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, ~b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        carry_d    = digit_sum[DIGIT];
        res_d      = (res_q >> DIGIT) | (SIZE'(digit_sum[DIGIT-1:0]) << (SIZE - DIGIT));
        ovf_d      = (a_sign_q != b_sign_q) && (res_d[SIZE-1] != a_sign_q);
        last_digit = (cnt_q == CNT_W'(N - 1));
        diff_d     = res_d;
`ifdef SUB_SATURATE_EN
        if (ovf_d) begin
            diff_d = a_sign_q ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
        end
`endif
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        carry_q  <= ~bus.bin;
                        a_sign_q <= bus.a[SIZE-1];
                        b_sign_q <= bus.b[SIZE-1];
                        cnt_q    <= '0;
                        res_q    <= '0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= carry_d;
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + 1'b1;
                    // Results only update on the final digit so diff stays held during RUN.
                    if (last_digit) begin
                        diff_q  <= diff_d;
                        bout_q  <= ~carry_d;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.bout     = bout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_signed_subtractor_seq.sv
// Self-checking bench for signed_subtractor_seq: directed cases plus randomized operands
// checked against an integer-arithmetic reference model.
module tb_signed_subtractor_seq;
    localparam int SIZE  = 8;
    localparam int DIGIT = 2;
    localparam int N     = SIZE / DIGIT;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [SIZE-1:0] held_diff;
    logic            held_bout, held_ovf;

    signed_subtractor_seq_if #(.SIZE(SIZE)) bus ();

    signed_subtractor_seq #(.SIZE(SIZE), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operand values.
    function automatic void ref_model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                      input logic bin, output logic [SIZE-1:0] d,
                                      output logic bo, output logic ov);
        int sr, ua, ub;
        logic [31:0] r;
        sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ua = int'(a);
        ub = int'(b);
        r  = sr;
        ov = (sr > 127) || (sr < -128);
        bo = (ua < ub + int'(bin));
        d  = r[SIZE-1:0];
`ifdef SUB_SATURATE_EN
        if (ov) d = (sr > 127) ? 8'h7F : 8'h80;
`endif
    endfunction

    // Launch from a ready cycle (#1 after an edge); returns #1 after the edge where done is seen.
    task automatic op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic bin,
                      input bit hold_start, input bit idle_after);
        logic [SIZE-1:0] ed;
        logic eb, eo;
        int cycles;
        ref_model(a, b, bin, ed, eb, eo);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        @(posedge clk);
        #1;
        if (!hold_start) bus.start = 1'b0;
        bus.a   = $urandom();
        bus.b   = $urandom();
        bus.bin = 1'($urandom());
        cycles = 0;
        while (!bus.done && cycles < 3 * N) begin
            check("busy_in_run", bus.busy, 1);
            check("ready_in_run", bus.ready, 0);
            check("diff_held", bus.diff, held_diff);
            @(posedge clk);
            #1;
            cycles++;
        end
        check("latency", cycles, N);
        bus.start = 1'b0;
        check("diff", bus.diff, ed);
        check("bout", bus.bout, eb);
        check("overflow", bus.overflow, eo);
        check("ready_at_done", bus.ready, 1);
        check("busy_at_done", bus.busy, 0);
        held_diff = ed;
        held_bout = eb;
        held_ovf  = eo;
        if (idle_after) begin
            @(posedge clk);
            #1;
            check("done_one_pulse", bus.done, 0);
            check("ready_after", bus.ready, 1);
            check("diff_held_done", bus.diff, held_diff);
            check("bout_held_done", bus.bout, held_bout);
            check("ovf_held_done", bus.overflow, held_ovf);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        held_diff = '0;
        held_bout = 1'b0;
        held_ovf  = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_bout", bus.bout, 0);
        check("rst_ovf", bus.overflow, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        op(8'h05, 8'h03, 1'b0, 1'b0, 1'b1);
        op(8'h03, 8'h05, 1'b0, 1'b0, 1'b1);
        op(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        op(8'h80, 8'h01, 1'b0, 1'b0, 1'b1);
        op(8'h7F, 8'hFF, 1'b0, 1'b0, 1'b1);
        // start held high throughout RUN, dropped in the done cycle
        op(8'h22, 8'h11, 1'b0, 1'b1, 1'b1);
        // back-to-back: start asserted in the done cycle
        op(8'h30, 8'h05, 1'b1, 1'b0, 1'b0);
        op(8'h10, 8'h01, 1'b0, 1'b0, 1'b1);

        // Reset mid-RUN: outputs drop immediately, no done pulse afterwards.
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h12;
        bus.bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", bus.ready, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_diff", bus.diff, 0);
        check("mid_rst_bout", bus.bout, 0);
        check("mid_rst_ovf", bus.overflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        held_diff = '0;
        held_bout = 1'b0;
        held_ovf  = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk);
            #1;
            check("no_done_after_abort", bus.done, 0);
        end
        op(8'h40, 8'h20, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            op(SIZE'($urandom()), SIZE'($urandom()), 1'($urandom()),
               1'($urandom()), 1'($urandom()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/signed_subtractor_seq.md
Name: signed_subtractor_seq

Overview:
Digit-serial signed subtractor for the FFT datapath. Computes diff = a - b - bin over SIZE/DIGIT clock cycles using a start/done handshake. Reports borrow out and two's-complement overflow. It is the subtract-direction counterpart of the team's combinational signed adder, used on butterfly difference legs where area matters more than latency.

Parameters:
SIZE, 8, operand and result width in bits (two's complement); must be an integer multiple of DIGIT
DIGIT, 2, bits processed per clock cycle; legal values 1..SIZE
(Derived: N = SIZE/DIGIT, the number of compute cycles.)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only while ready=1
a  input  SIZE  minuend, signed; sampled on the accepted start edge
b  input  SIZE  subtrahend, signed; sampled on the accepted start edge
bin  input  1  borrow in; sampled on the accepted start edge
ready  output  1  high in IDLE and DONE states
busy  output  1  high in RUN state
done  output  1  one-cycle pulse when the result becomes valid
diff  output  SIZE  result a - b - bin (SIZE LSBs), held stable until the next accepted start
bout  output  1  borrow out (1 when unsigned a < b + bin)
overflow  output  1  signed overflow of the subtraction

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- Reset forces state to IDLE and sets: ready=1, busy=0, done=0, diff=0, bout=0, overflow=0. Internal operand shift registers, digit counter and carry are cleared.
- States are IDLE, RUN and DONE.
- IDLE: ready=1. start=1 at edge E latches a, b and bin, sets carry = ~bin, clears the counter and moves to RUN.
- Identity used: a - b - bin = a + ~b + (1 - bin).
- RUN: busy=1, ready=0. On each edge, the DIGIT LSBs of a and ~b are added with carry.
  - The DIGIT-bit sum shifts into the top of the result register; a and b shift right by DIGIT.
  - carry takes the carry out of the digit add.
  - start is ignored in this state.
- After the N-th RUN edge (edge E+N):
  - State moves to DONE; done=1 for exactly that cycle.
  - diff holds the full result.
  - bout = ~final carry.
  - overflow = (a[SIZE-1] != b[SIZE-1]) && (diff[SIZE-1] != a[SIZE-1]), using the latched operand signs.
- Latency is exactly N cycles from the start edge to done high.
- DONE: ready=1, busy=0, done=0 after its first cycle. diff, bout and overflow stay held.
  - start=1 in DONE is accepted exactly as in IDLE: outputs remain held until the new result lands; done pulses again N cycles later.
  - Without start, the block stays in DONE. DONE behaves as IDLE apart from the held results.
- start asserted in the same cycle that done pulses is legal and is accepted, since ready=1 in DONE.
- Reset asserted mid-RUN aborts immediately to the reset values. No done pulse is produced for the aborted operation.
- DIGIT=SIZE is legal: a single RUN cycle, so latency is 1.

Optional Feature:
SUB_SATURATE_EN
- Defined: when overflow=1, diff is clamped instead of wrapping.
  - a non-negative: diff = 2^(SIZE-1)-1.
  - a negative: diff = -2^(SIZE-1).
  - overflow and bout still report the unsaturated result; timing is unchanged.
- Undefined: diff is the wrapped SIZE-bit result.

Test Plan:
1. Basic subtraction: SIZE=8, DIGIT=2, a=0x05, b=0x03, bin=0, start pulse -> done exactly 4 cycles later with diff=0x02, bout=0, overflow=0; busy high for those 4 cycles.
2. Negative result and borrow in:
   - a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, overflow=0.
   - a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, overflow=0.
3. Negative overflow: a=0x80, b=0x01 -> overflow=1, bout=0. Without SUB_SATURATE_EN, diff=0x7F; with it, diff=0x80.
4. Positive overflow: a=0x7F, b=0xFF -> overflow=1, bout=1. Without SUB_SATURATE_EN, diff=0x80; with it, diff=0x7F.
5. Handshake:
   - start held high through RUN -> no restart; exactly one done pulse.
   - start in the done cycle with a=0x10, b=0x01 -> second done 4 cycles later with diff=0x0F; first result held until then.
6. Reset mid-operation: assert reset 2 cycles after start -> outputs drop to the reset values asynchronously, with no done pulse. A new start after release computes correctly (e.g. 0x40-0x20 -> 0x20).
